// File: rtl/ldm_pkg.sv
// ldm_pkg: shared definitions for the LDM row shifter.
// Holds the row shifter FSM state encoding (3-bit codes plus an enum built
// from them) and the default geometry of the LED matrix column driver.
// No ports; imported by the interface, the frame buffer and the top.
// Optional feature macro used elsewhere in this slice: LDM_OVERRUN_CNT_EN.

package ldm_pkg;

    localparam int LDM_COLS     = 16;
    localparam int LDM_ROWS     = 16;
    localparam int LDM_SCLK_DIV = 2;
    localparam int LDM_ADDR_W   = 4;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_SHIFT_LO = 3'd2;
    localparam logic [2:0] ST_SHIFT_HI = 3'd3;
    localparam logic [2:0] ST_LATCH    = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE     = ST_IDLE,
        S_LOAD     = ST_LOAD,
        S_SHIFT_LO = ST_SHIFT_LO,
        S_SHIFT_HI = ST_SHIFT_HI,
        S_LATCH    = ST_LATCH,
        S_DONE     = ST_DONE
    } ldm_state_e;

endpackage

// File: rtl/ldm_row_shifter_if.sv
// ldm_row_shifter_if: bundle of the host write port, the scan FSM row strobe
// and the column driver outputs of the LDM row shifter.
// Parameters: COLS (row width), ADDR_W (row address width).
// Signals:
//   wr_en, wr_addr, wr_data     host frame-buffer write port
//   ldm_addr_en, ldm_addr       row strobe and row address from the scan FSM
//   ldm_sdata, ldm_sclk         serial column data and shift clock
//   ldm_latch, ldm_oe_n         column latch pulse, active-low output enable
//   busy, row_done              row in flight, one-cycle row-latched pulse
//   overrun_cnt                 ignored-strobe counter (only with LDM_OVERRUN_CNT_EN)
// Modports: master = host/scan side, slave = the row shifter.

interface ldm_row_shifter_if
    import ldm_pkg::*;
#(
    parameter int COLS   = LDM_COLS,
    parameter int ADDR_W = LDM_ADDR_W
);

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [COLS-1:0]   wr_data;
    logic              ldm_addr_en;
    logic [ADDR_W-1:0] ldm_addr;
    logic              ldm_sdata;
    logic              ldm_sclk;
    logic              ldm_latch;
    logic              ldm_oe_n;
    logic              busy;
    logic              row_done;
`ifdef LDM_OVERRUN_CNT_EN
    logic [7:0]        overrun_cnt;
`endif

    modport master (
`ifdef LDM_OVERRUN_CNT_EN
        input  overrun_cnt,
`endif
        output wr_en, wr_addr, wr_data, ldm_addr_en, ldm_addr,
        input  ldm_sdata, ldm_sclk, ldm_latch, ldm_oe_n, busy, row_done
    );

    modport slave (
`ifdef LDM_OVERRUN_CNT_EN
        output overrun_cnt,
`endif
        input  wr_en, wr_addr, wr_data, ldm_addr_en, ldm_addr,
        output ldm_sdata, ldm_sclk, ldm_latch, ldm_oe_n, busy, row_done
    );

endinterface

// File: rtl/ldm_fb_ram.sv
// ldm_fb_ram: ROWS x COLS frame buffer register file.
// One synchronous write port, one combinational read port. A read in the
// same cycle as a write to the same row returns the old contents, because
// the write only lands at the clock edge. Writes to rows >= ROWS are dropped.
// No reset: contents are undefined until the host writes them.
// Ports:
//   clk      system clock
//   wr_en    write strobe
//   wr_addr  write row address
//   wr_data  write row pattern
//   rd_addr  read row address (caller keeps it below ROWS)
//   rd_data  read row pattern

module ldm_fb_ram #(
    parameter int COLS   = 16,
    parameter int ROWS   = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [COLS-1:0]   wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [COLS-1:0]   rd_data
);

    localparam logic [ADDR_W:0] ROWS_LIM = (ADDR_W + 1)'(ROWS);

    logic [COLS-1:0] mem [ROWS];
    logic            wr_ok;

    // Out-of-range host addresses must not alias onto a real row.
    assign wr_ok = wr_en && ({1'b0, wr_addr} < ROWS_LIM);

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ldm_row_shifter.sv
// ldm_row_shifter: downstream stage of the LDM scan FSM.
// Holds the frame buffer the host writes and, on each row strobe, shifts the
// addressed row MSB-first to the column driver, latches it and pulses
// row_done. Strobes arriving while a row is in flight are ignored.
// Parameters: COLS (2..32), ROWS, SCLK_DIV (>=1, clk cycles per sclk half
// period and latch pulse length).
// Ports:
//   clk   system clock, rising edge
//   rstn  asynchronous active-low reset
//   bus   ldm_row_shifter_if.slave (host write, row strobe, column driver)
// Optional feature macro: LDM_OVERRUN_CNT_EN adds bus.overrun_cnt, a
// saturating count of cycles with a strobe that was ignored.

module ldm_row_shifter
    import ldm_pkg::*;
#(
    parameter int COLS     = LDM_COLS,
    parameter int ROWS     = LDM_ROWS,
    parameter int SCLK_DIV = LDM_SCLK_DIV
) (
    input  logic                clk,
    input  logic                rstn,
    ldm_row_shifter_if.slave    bus
);

    localparam int ADDR_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CNT_W  = $clog2(COLS);
    localparam int DIV_W  = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;

    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(COLS - 1);
    localparam logic [DIV_W-1:0]  LAST_DIV = DIV_W'(SCLK_DIV - 1);
    localparam logic [ADDR_W:0]   ROWS_LIM = (ADDR_W + 1)'(ROWS);

    ldm_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [COLS-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
    logic              lit_q, lit_d;

    logic [COLS-1:0]   fb_rdata;
    logic              div_last;

    ldm_fb_ram #(
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_fb_ram (
        .clk     (clk),
        .wr_en   (bus.wr_en),
        .wr_addr (bus.wr_addr),
        .wr_data (bus.wr_data),
        .rd_addr (addr_q),
        .rd_data (fb_rdata)
    );

    assign div_last = (div_cnt_q == LAST_DIV);

    // Next-state logic. The row is snapshotted into shreg in LOAD, so host
    // writes after that only show on the next scan. lit records that a row
    // has been latched at least once, which is what unblanks the display.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        lit_d     = lit_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ldm_addr_en) begin
                    addr_d  = ({1'b0, bus.ldm_addr} < ROWS_LIM) ? bus.ldm_addr : '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                shreg_d   = fb_rdata;
                bit_cnt_d = '0;
                div_cnt_d = '0;
                state_d   = S_SHIFT_LO;
            end
            S_SHIFT_LO: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    state_d   = S_SHIFT_HI;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_SHIFT_HI: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    shreg_d   = {shreg_q[COLS-2:0], 1'b0};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    state_d   = (bit_cnt_q == LAST_BIT) ? S_LATCH : S_SHIFT_LO;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                if (div_last) begin
                    div_cnt_d = '0;
                    lit_d     = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
            lit_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
            lit_q     <= lit_d;
        end
    end

    // Column driver outputs decode straight from the state, so an async
    // reset blanks and idles the driver without waiting for a clock edge.
    // oe_n stays low outside LATCH once a row has been latched, keeping the
    // previous row lit while the next one shifts in.
    logic sdata_o, sclk_o, latch_o, oe_n_o, row_done_o;

    always_comb begin
        sdata_o    = 1'b0;
        sclk_o     = 1'b0;
        latch_o    = 1'b0;
        oe_n_o     = ~lit_q;
        row_done_o = 1'b0;
        case (state_q)
            S_SHIFT_LO: begin
                sdata_o = shreg_q[COLS-1];
            end
            S_SHIFT_HI: begin
                sdata_o = shreg_q[COLS-1];
                sclk_o  = 1'b1;
            end
            S_LATCH: begin
                latch_o = 1'b1;
                oe_n_o  = 1'b1;
            end
            S_DONE: begin
                row_done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.ldm_sdata = sdata_o;
    assign bus.ldm_sclk  = sclk_o;
    assign bus.ldm_latch = latch_o;
    assign bus.ldm_oe_n  = oe_n_o;
    assign bus.row_done  = row_done_o;
    assign bus.busy      = (state_q != S_IDLE);

`ifdef LDM_OVERRUN_CNT_EN
    // Counts every cycle a strobe is present but cannot be taken, which
    // includes the DONE cycle; saturates rather than wrapping.
    logic [7:0] overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (bus.ldm_addr_en && (state_q != S_IDLE) && (overrun_q != 8'hFF)) begin
            overrun_d = overrun_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            overrun_q <= '0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign bus.overrun_cnt = overrun_q;
`endif

endmodule

// File: tb/tb_ldm_row_shifter.sv
// tb_ldm_row_shifter: self-checking bench for ldm_row_shifter.
// Expected column bits are pushed to a queue from a bench-side frame buffer
// model whenever a row strobe is issued and popped at each ldm_sclk rising
// edge. Directed steps cover idle reset, a basic row, strobes while busy and
// in the DONE cycle, a LOAD-cycle write collision, reset mid-row and a full
// walking-one scan sweep. Build with LDM_OVERRUN_CNT_EN to also check
// overrun_cnt.

module tb_ldm_row_shifter;
    import ldm_pkg::*;

    localparam int COLS     = 16;
    localparam int ROWS     = 16;
    localparam int SCLK_DIV = 2;
    // row_done is the DONE-state output; the flop that sees it is edge
    // 2 + 2*COLS*SCLK_DIV + SCLK_DIV = 68, so the bench's negedge sample
    // that shows it follows edge 67.
    localparam int DONE_EDGE = 2 + 2 * COLS * SCLK_DIV + SCLK_DIV - 1;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    ldm_row_shifter_if #(.COLS(COLS), .ADDR_W(4)) bus ();

    ldm_row_shifter #(
        .COLS     (COLS),
        .ROWS     (ROWS),
        .SCLK_DIV (SCLK_DIV)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int strobe_cyc = 0;
    int done_cnt   = 0;
    int latch_cyc  = 0;

    logic [COLS-1:0] model_fb [ROWS];
    bit              exp_q [$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.row_done === 1'b1) done_cnt++;
        if (bus.ldm_latch === 1'b1) latch_cyc++;
    end

    // The column driver samples sdata on the sclk rising edge.
    always @(posedge bus.ldm_sclk) begin
        compared++;
        assert (exp_q.size() > 0) else begin
            mismatched++;
            $error("[TB] FAIL sdata_extra observed=unexpected_shift expected=no_shift");
        end
        if (exp_q.size() > 0) begin
            checkOutput("sdata_bit", 32'(bus.ldm_sdata), 32'(exp_q.pop_front()));
        end
    end

    task automatic pushRow(input int row);
        for (int b = COLS - 1; b >= 0; b--) begin
            exp_q.push_back(model_fb[row][b]);
        end
    endtask

    // All drive tasks are called at a negedge and return at a later negedge.
    task automatic hostWrite(input int row, input logic [COLS-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'(row);
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
        if (row < ROWS) model_fb[row] = data;
    endtask

    task automatic applyStimulus(input int row, input bit expect_accept);
        if (expect_accept) pushRow(row);
        bus.ldm_addr_en = 1'b1;
        bus.ldm_addr    = 4'(row);
        @(negedge clk);
        bus.ldm_addr_en = 1'b0;
        if (expect_accept) strobe_cyc = cyc;
    endtask

    task automatic waitEdge(input int k);
        while (cyc - strobe_cyc < k) @(negedge clk);
    endtask

    task automatic waitRowDone(output int edges);
        edges = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.row_done === 1'b1) begin
                edges = cyc - strobe_cyc;
                break;
            end
        end
    endtask

    task automatic finishRow();
        int e;
        waitRowDone(e);
        checkOutput("row_done_edge", 32'(e), 32'(DONE_EDGE));
        @(negedge clk);
        checkOutput("row_done_width", 32'(bus.row_done), 32'd0);
        checkOutput("busy_after_row", 32'(bus.busy), 32'd0);
        checkOutput("oe_n_after_row", 32'(bus.ldm_oe_n), 32'd0);
        checkOutput("bits_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int l0;
        int d0;
        int e;

        bus.wr_en       = 1'b0;
        bus.wr_addr     = '0;
        bus.wr_data     = '0;
        bus.ldm_addr_en = 1'b0;
        bus.ldm_addr    = '0;
        for (int r = 0; r < ROWS; r++) model_fb[r] = '0;

        // Reset held for 100 cycles with no strobe.
        repeat (100) begin
            @(negedge clk);
            checkOutput("rst_oe_n", 32'(bus.ldm_oe_n), 32'd1);
            checkOutput("rst_sclk", 32'(bus.ldm_sclk), 32'd0);
            checkOutput("rst_latch", 32'(bus.ldm_latch), 32'd0);
            checkOutput("rst_busy", 32'(bus.busy), 32'd0);
            checkOutput("rst_row_done", 32'(bus.row_done), 32'd0);
        end
        rstn = 1'b1;
        @(negedge clk);

        // Basic row: display still blanked while the first row shifts.
        $display("[TB] basic row");
        hostWrite(3, 16'hA5C3);
        l0 = latch_cyc;
        applyStimulus(3, 1'b1);
        waitEdge(1);
        checkOutput("busy_in_load", 32'(bus.busy), 32'd1);
        waitEdge(10);
        checkOutput("oe_n_first_row", 32'(bus.ldm_oe_n), 32'd1);
        finishRow();
        checkOutput("latch_len", 32'(latch_cyc - l0), 32'(SCLK_DIV));

        // Second strobe at edge 20 of a running row is dropped.
        $display("[TB] strobe while busy");
        hostWrite(1, 16'h1234);
        hostWrite(2, 16'hFEDC);
        d0 = done_cnt;
        applyStimulus(1, 1'b1);
        waitEdge(10);
        checkOutput("oe_n_lit_while_shift", 32'(bus.ldm_oe_n), 32'd0);
        waitEdge(19);
        applyStimulus(2, 1'b0);
        checkOutput("busy_after_drop", 32'(bus.busy), 32'd1);
        finishRow();
        repeat (80) @(negedge clk);
        checkOutput("single_row_done", 32'(done_cnt - d0), 32'd1);
`ifdef LDM_OVERRUN_CNT_EN
        checkOutput("overrun_busy", 32'(bus.overrun_cnt), 32'd1);
`endif

        // A strobe coinciding with row_done is ignored as well.
        $display("[TB] strobe in DONE cycle");
        hostWrite(4, 16'h00FF);
        applyStimulus(4, 1'b1);
        waitRowDone(e);
        checkOutput("row_done_edge_r4", 32'(e), 32'(DONE_EDGE));
        applyStimulus(4, 1'b0);
        checkOutput("busy_done_strobe", 32'(bus.busy), 32'd0);
        repeat (5) @(negedge clk);
        checkOutput("busy_done_strobe_late", 32'(bus.busy), 32'd0);
        checkOutput("bits_left_r4", 32'(exp_q.size()), 32'd0);
`ifdef LDM_OVERRUN_CNT_EN
        checkOutput("overrun_done", 32'(bus.overrun_cnt), 32'd2);
`endif

        // Write to the loading row lands after LOAD has read the old data.
        $display("[TB] write collision");
        hostWrite(5, 16'hFFFF);
        applyStimulus(5, 1'b1);
        hostWrite(5, 16'h0000);
        finishRow();
        applyStimulus(5, 1'b1);
        finishRow();

        // Reset mid-row: outputs drop immediately and nothing is latched.
        $display("[TB] reset mid-row");
        hostWrite(7, 16'h0F0F);
        l0 = latch_cyc;
        applyStimulus(7, 1'b1);
        waitEdge(30);
        checkOutput("busy_before_reset", 32'(bus.busy), 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("mid_rst_sclk", 32'(bus.ldm_sclk), 32'd0);
        checkOutput("mid_rst_sdata", 32'(bus.ldm_sdata), 32'd0);
        checkOutput("mid_rst_latch", 32'(bus.ldm_latch), 32'd0);
        checkOutput("mid_rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("mid_rst_row_done", 32'(bus.row_done), 32'd0);
        checkOutput("mid_rst_oe_n", 32'(bus.ldm_oe_n), 32'd1);
        exp_q.delete();
        repeat (3) @(negedge clk);
        checkOutput("no_latch_on_abort", 32'(latch_cyc - l0), 32'd0);
`ifdef LDM_OVERRUN_CNT_EN
        checkOutput("overrun_reset", 32'(bus.overrun_cnt), 32'd0);
`endif
        rstn = 1'b1;
        @(negedge clk);
        applyStimulus(7, 1'b1);
        finishRow();
        checkOutput("latch_after_reset", 32'(latch_cyc - l0), 32'(SCLK_DIV));

        // Walking-one sweep, each strobe issued from IDLE after row_done.
        $display("[TB] scan sweep");
        for (int r = 0; r < ROWS; r++) hostWrite(r, 16'h0001 << r);
        d0 = done_cnt;
        for (int r = 0; r < ROWS; r++) begin
            applyStimulus(r, 1'b1);
            finishRow();
        end
        @(negedge clk);
        checkOutput("sweep_row_done", 32'(done_cnt - d0), 32'(ROWS));
`ifdef LDM_OVERRUN_CNT_EN
        checkOutput("sweep_overrun", 32'(bus.overrun_cnt), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ldm_row_shifter.md
Name: ldm_row_shifter

Overview:
- Downstream stage of the LDM scan FSM. It consumes the row strobe and row address and produces the column data for that row.
- Holds a ROWS x COLS frame buffer that the host writes.
- On each row strobe, it serialises the addressed row MSB-first onto the matrix column driver (data, shift clock, latch, output enable).

Parameters:
- COLS, 16, columns per row and shift length (2..32).
- ROWS, 16, rows in the frame buffer. The address width is clog2(ROWS), which is 4 at the default.
- SCLK_DIV, 2, clk cycles per ldm_sclk half-period, and the length of the latch pulse (>=1).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rstn  in  1  asynchronous active-low reset.
- wr_en  in  1  host frame-buffer write strobe.
- wr_addr  in  4  host row address.
- wr_data  in  COLS  host row pattern (1 = LED on).
- ldm_addr_en  in  1  row strobe from the scan FSM.
- ldm_addr  in  4  row address from the scan FSM; valid while ldm_addr_en is high.
- ldm_sdata  out  1  serial column data.
- ldm_sclk  out  1  column shift clock; the driver samples on its rising edge.
- ldm_latch  out  1  column latch pulse.
- ldm_oe_n  out  1  active-low output enable; 1 = blanked.
- busy  out  1  high while a row is in flight.
- row_done  out  1  one-cycle pulse when a row has been latched.

Behaviour:
- Reset (async, rstn=0):
  - State goes to IDLE. sdata, sclk, latch, busy and row_done go to 0. oe_n goes to 1.
  - Shift register and counters clear. Frame buffer contents are don't-care.
  - Reset asserted mid-row aborts the row immediately. The partial row is never latched.
- FSM states: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH, DONE.
- IDLE:
  - ldm_addr_en=1 at an edge captures ldm_addr, then goes to LOAD.
  - ldm_addr values >= ROWS are treated as row 0.
- LOAD (1 cycle):
  - Shift register is loaded from fb[addr]. busy=1.
  - If a host write to the same address occurs in this cycle, LOAD gets the OLD data (read-before-write).
- SHIFT_LO (SCLK_DIV cycles): sclk=0, sdata=shift register MSB.
- SHIFT_HI (SCLK_DIV cycles): sclk=1, sdata held.
  - On exit, shift left by 1 and increment the bit counter.
  - After COLS bits go to LATCH; otherwise return to SHIFT_LO.
- LATCH (SCLK_DIV cycles): latch=1, oe_n=1 (blank), sclk=0, sdata=0.
- DONE (1 cycle): row_done=1, oe_n=0, latch=0. Next state is IDLE, where busy=0.
- oe_n:
  - Stays 1 from reset until the first LATCH completes.
  - Afterwards it is 0 except during LATCH, so the previous row stays lit while the next one shifts.
- Latency: the row_done pulse occurs at edge 2 + 2*COLS*SCLK_DIV + SCLK_DIV after the strobe edge. With defaults this is edge 68.
- ldm_addr_en while busy (LOAD through DONE) is ignored. No queueing.
- ldm_addr_en in the same cycle as row_done is also ignored; the next strobe is accepted from IDLE.
- Host writes:
  - Accepted every cycle regardless of state.
  - wr_addr >= ROWS is dropped.
  - A write to the row currently shifting does not affect that row; it shows on the next scan.

Optional Feature:
- LDM_OVERRUN_CNT_EN defined:
  - Adds output overrun_cnt [7:0]. It saturates at 255 and resets to 0.
  - It increments on every cycle where ldm_addr_en=1 and the strobe is ignored (busy or DONE).
- Undefined: the port and the counter are absent. Behaviour is otherwise identical.

Decomposition:
- Package ldm_pkg holds:
  - the state encoding (3-bit localparams for the 6 states);
  - default constants LDM_COLS=16, LDM_ROWS=16, LDM_SCLK_DIV=2;
  - LDM_ADDR_W=4.
- Sub-module ldm_fb_ram: ROWS x COLS register file with one synchronous write port and one read port. It is read-before-write and has no reset.

Test Plan:
- Reset then idle: with rstn low and no strobe for 100 cycles, oe_n=1 and sclk=latch=busy=row_done=0 throughout.
- Basic row:
  - Stimulus: write fb[3]=16'hA5C3, then pulse ldm_addr_en with ldm_addr=3.
  - Required: sdata sampled at the 16 sclk rising edges equals 1010_0101_1100_0011; latch high for 2 cycles; row_done at edge 68; oe_n=0 afterwards.
- Strobe while busy:
  - Stimulus: strobe row 1 at 0, then a second strobe with row 2 at edge 20.
  - Required: only row 1 is shifted; one row_done; overrun_cnt=1 with LDM_OVERRUN_CNT_EN defined.
- Write collision:
  - Stimulus: fb[5]=16'hFFFF; strobe row 5 with a write of fb[5]=16'h0000 in the LOAD cycle.
  - Required: all 16 shifted bits are 1; the next scan of row 5 shifts all 0.
- Reset mid-row: rstn low at edge 30 of a shift → all outputs return to reset values within the same cycle and no latch pulse occurs; a strobe after rstn=1 runs a full 68-cycle row.
- Scan sweep with the scan FSM attached:
  - Stimulus: rows 0..15 loaded with a walking-one pattern (fb[r] = 1<<r); strobes for rows 0..15 issued in order, each accepted from IDLE after the previous row_done.
  - Required: 16 row_done pulses; each row shifts its walking-one pattern; no overruns.
